// File: rtl/pll_lock_supervisor.sv
// Supervises NUM_PLL PLLs: pulses a shared PLL reset, waits for lock, qualifies stability, retries or fails.
// Optional sticky UNLOCK_SEEN output is compiled in with `define PLL_SUPERVISOR_UNLOCK_LATCH_EN.
module pll_lock_supervisor #(
  parameter int NUM_PLL      = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 7
) (
  input  logic               CLKIN,
  input  logic               RESETN,
  input  logic [NUM_PLL-1:0] LOCKED,
  output logic               PLL_RST,
  output logic               READY,
  output logic               FAIL,
  output logic [2:0]         STATE,
  output logic [7:0]         RETRY_CNT
`ifdef PLL_SUPERVISOR_UNLOCK_LATCH_EN
  ,
  output logic               UNLOCK_SEEN
`endif
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
  localparam int CNT_W     = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRY);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAILED = 3'd4;

  logic [NUM_PLL-1:0] sync1_reg, sync2_reg;
  logic               all_lk;
  logic [2:0]         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [7:0]         retry_reg, retry_next;
  logic               pll_rst_reg, ready_reg, fail_reg;

  // LOCKED is asynchronous to CLKIN; only the second stage is ever consumed.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= LOCKED;
      sync2_reg <= sync1_reg;
    end
  end

  assign all_lk = &sync2_reg;

`ifdef PLL_SUPERVISOR_UNLOCK_LATCH_EN
  logic unlock_reg, unlock_next;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
`ifdef PLL_SUPERVISOR_UNLOCK_LATCH_EN
    unlock_next = unlock_reg;
`endif
    case (state_reg)
      S_RESET: begin
        if (cnt_reg == RST_LAST) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      S_WAIT: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (all_lk) begin
          state_next = S_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TO_LAST) begin
          cnt_next = '0;
          if (retry_reg < RETRY_LIMIT) begin
            retry_next = retry_reg + 8'd1;
            state_next = S_RESET;
          end else begin
            state_next = S_FAILED;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      S_STABLE: begin
        if (!all_lk) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      S_RUN: begin
        // Loss of lock in RUN always retries; the budget only limits startup attempts.
        if (!all_lk) begin
          state_next = S_RESET;
          cnt_next   = '0;
          if (retry_reg != 8'hFF) begin
            retry_next = retry_reg + 8'd1;
          end
`ifdef PLL_SUPERVISOR_UNLOCK_LATCH_EN
          unlock_next = 1'b1;
`endif
        end
      end
      S_FAILED: begin
        state_next = S_FAILED;
      end
      default: begin
        state_next = S_RESET;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as STATE.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_reg   <= S_RESET;
      cnt_reg     <= '0;
      retry_reg   <= '0;
      pll_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
      fail_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      retry_reg   <= retry_next;
      pll_rst_reg <= (state_next == S_RESET) || (state_next == S_FAILED);
      ready_reg   <= (state_next == S_RUN);
      fail_reg    <= (state_next == S_FAILED);
    end
  end

`ifdef PLL_SUPERVISOR_UNLOCK_LATCH_EN
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      unlock_reg <= 1'b0;
    end else begin
      unlock_reg <= unlock_next;
    end
  end

  assign UNLOCK_SEEN = unlock_reg;
`endif

  assign PLL_RST   = pll_rst_reg;
  assign READY     = ready_reg;
  assign FAIL      = fail_reg;
  assign STATE     = state_reg;
  assign RETRY_CNT = retry_reg;

endmodule
